fetch_unit: RTL and testbench



---
 rtl/pipeline_pkg.sv | 17 +
 rtl/pc_next_sel.sv | 56 +++++
 rtl/fetch_unit.sv | 164 ++++++++++++++++
 tb/tb_fetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the IF stage.
// Contents: datapath width, instruction size, the canonical NOP word
// (addi x0,x0,0) and the fetch state encoding.
package pipeline_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection for the fetch unit.
// The priority order is: redirect, then advance by one instruction, then hold.
// Optional build macro MISALIGN_TRAP_EN: a redirect to a target that is not
// word aligned loads TRAP_VEC instead and raises misalign_o.
// Ports:
//   pc_i        current fetch PC
//   pc_plus4_i  current fetch PC + 4
//   redirect_i  taken branch/jump from EX
//   target_i    redirect target from EX
//   advance_i   the buffered word leaves this cycle, so step to the next PC
//   pc_next_o   PC to load at the next edge
//   misalign_o  (MISALIGN_TRAP_EN only) the redirect target was misaligned
module pc_next_sel
  import pipeline_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc_plus4_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] target_i,
  input  logic            advance_i,
  output logic [XLEN-1:0] pc_next_o
`ifdef MISALIGN_TRAP_EN
  ,
  output logic            misalign_o
`endif
);

`ifdef MISALIGN_TRAP_EN
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0004;
`endif

  // Instruction fetches are always word aligned, so the low bits of a target are dropped.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES - 1));

  always_comb begin
    pc_next_o = pc_i;
`ifdef MISALIGN_TRAP_EN
    misalign_o = 1'b0;
`endif
    if (redirect_i) begin
`ifdef MISALIGN_TRAP_EN
      if (target_i[1:0] != 2'b00) begin
        misalign_o = 1'b1;
        pc_next_o  = TRAP_VEC;
      end else begin
        pc_next_o  = target_i & ALIGN_MASK;
      end
`else
      pc_next_o = target_i & ALIGN_MASK;
`endif
    end else if (advance_i) begin
      pc_next_o = pc_plus4_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF-stage fetch unit. It owns PCF, keeps at most one instruction-memory
// request outstanding and buffers the returned word. The buffered word is
// presented to IF/ID, and a NOP is presented while no valid word is held.
// Optional build macro MISALIGN_TRAP_EN: misaligned redirects go to TRAP_VEC
// and pulse MisalignF for one cycle.
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   StallF                     hazard unit: hold the buffered word and PC
//   PCSrcE, PCTargetE          EX redirect and its target
//   imem_req, imem_addr        request to instruction memory (address = PCF)
//   imem_gnt                   memory accepts the request this cycle
//   imem_rvalid, imem_rdata    memory response
//   PCF, PCPlus4F, InstrF      values for IF/ID
//   InstrValidF, FetchBusyF    InstrF holds a real word / its inverse
//   MisalignF                  (MISALIGN_TRAP_EN only) misaligned-redirect pulse
module fetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
`ifdef MISALIGN_TRAP_EN
  ,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0004
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F,
  output logic [XLEN-1:0] InstrF,
  output logic            InstrValidF,
  output logic            FetchBusyF
`ifdef MISALIGN_TRAP_EN
  ,
  output logic            MisalignF
`endif
);

  fetch_state_t    state_q, state_d;
  logic            drop_q, drop_d;
  logic            buf_valid_q, buf_valid_d;
  logic [XLEN-1:0] buffer_q, buffer_d;
  logic [XLEN-1:0] pcf_q, pcf_d;
  logic            req;
  logic            advance;
`ifdef MISALIGN_TRAP_EN
  logic            misalign_q, misalign_d;
`endif

  // While a stale response is still owed, a new request is held back so
  // that only one transaction is ever outstanding.
  assign req         = (state_q == S_REQ) && !drop_q;
  assign advance     = (state_q == S_HOLD) && !StallF;

  assign imem_req    = req;
  assign imem_addr   = pcf_q;
  assign PCF         = pcf_q;
  assign PCPlus4F    = pcf_q + XLEN'(INSTR_BYTES);
  assign InstrF      = buf_valid_q ? buffer_q : NOP_INSTR;
  assign InstrValidF = buf_valid_q;
  assign FetchBusyF  = !buf_valid_q;

`ifdef MISALIGN_TRAP_EN
  assign MisalignF = misalign_q;

  pc_next_sel #(.TRAP_VEC(TRAP_VEC)) u_pc_next_sel (
    .pc_i       (pcf_q),
    .pc_plus4_i (PCPlus4F),
    .redirect_i (PCSrcE),
    .target_i   (PCTargetE),
    .advance_i  (advance),
    .pc_next_o  (pcf_d),
    .misalign_o (misalign_d)
  );
`else
  pc_next_sel u_pc_next_sel (
    .pc_i       (pcf_q),
    .pc_plus4_i (PCPlus4F),
    .redirect_i (PCSrcE),
    .target_i   (PCTargetE),
    .advance_i  (advance),
    .pc_next_o  (pcf_d)
  );
`endif

  // Request / wait / hold sequencing. A redirect overrides everything, and it
  // remembers whether a response is still owed for the abandoned request.
  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    buf_valid_d = buf_valid_q;
    buffer_d    = buffer_q;

    case (state_q)
      S_REQ: begin
        if (drop_q) begin
          if (imem_rvalid) drop_d = 1'b0;
        end else if (imem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            buffer_d    = imem_rdata;
            buf_valid_d = 1'b1;
            state_d     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!StallF) begin
          buf_valid_d = 1'b0;
          state_d     = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (PCSrcE) begin
      state_d     = S_REQ;
      buf_valid_d = 1'b0;
      buffer_d    = buffer_q;
      drop_d      = ((state_q == S_WAIT) && !imem_rvalid)
                 || (req && imem_gnt)
                 || ((state_q == S_REQ) && drop_q && !imem_rvalid);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_REQ;
      drop_q      <= 1'b0;
      buf_valid_q <= 1'b0;
      buffer_q    <= NOP_INSTR;
      pcf_q       <= RESET_PC;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      buf_valid_q <= buf_valid_d;
      buffer_q    <= buffer_d;
      pcf_q       <= pcf_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit with a behavioural instruction memory whose latency
// can be changed between tests. Words captured by IF/ID are checked in order
// against the expected words queued by each test.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } cap_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic [31:0] InstrF;
  logic        InstrValidF;
  logic        FetchBusyF;
`ifdef MISALIGN_TRAP_EN
  logic        MisalignF;
`endif

  int vectors = 0;
  int miscompares = 0;
  cap_t expQ[$];

  logic        gntEn = 1'b0;
  int          memLat = 1;
  logic        memPend = 1'b0;
  int          memCnt = 0;
  logic [31:0] memAddr = 32'h0;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .StallF      (StallF),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .PCF         (PCF),
    .PCPlus4F    (PCPlus4F),
    .InstrF      (InstrF),
    .InstrValidF (InstrValidF),
    .FetchBusyF  (FetchBusyF)
`ifdef MISALIGN_TRAP_EN
    ,
    .MisalignF   (MisalignF)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h0010_0113;
      default: return (a << 8) | 32'h13;
    endcase
  endfunction

  // Instruction memory: the response arrives memLat cycles after the grant edge.
  assign imem_gnt    = gntEn;
  assign imem_rvalid = memPend && (memCnt == 0);
  assign imem_rdata  = imem_rvalid ? memWord(memAddr) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (imem_rvalid)  memPend <= 1'b0;
    else if (memPend) memCnt <= memCnt - 1;
    if (imem_req && imem_gnt) begin
      memPend <= 1'b1;
      memCnt  <= memLat - 1;
      memAddr <= imem_addr;
    end
  end

  // IF/ID captures at the next edge whenever a valid word is shown without stall or redirect.
  always @(negedge clk) begin : capture_monitor
    cap_t e;
    if (reset === 1'b0 && InstrValidF === 1'b1 && StallF === 1'b0 && PCSrcE === 1'b0) begin
      vectors++;
      if (expQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL capture_unexpected: got pc=%h instr=%h, required no capture", PCF, InstrF);
      end else begin
        e = expQ.pop_front();
        if (PCF !== e.pc || InstrF !== e.instr) begin
          miscompares++;
          $display("[TB] FAIL capture: got pc=%h instr=%h, required pc=%h instr=%h", PCF, InstrF, e.pc, e.instr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0; gntEn = 1'b0; memLat = 1;
    tick();
    tick();
    vectors++; if (PCF !== 32'h0)       begin miscompares++; $display("[TB] FAIL reset_pcf: got %h, required %h", PCF, 32'h0); end
    vectors++; if (PCPlus4F !== 32'h4)  begin miscompares++; $display("[TB] FAIL reset_pcplus4: got %h, required %h", PCPlus4F, 32'h4); end
    vectors++; if (InstrF !== NOP)      begin miscompares++; $display("[TB] FAIL reset_instr: got %h, required %h", InstrF, NOP); end
    vectors++; if (InstrValidF !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b, required 0", InstrValidF); end
    vectors++; if (FetchBusyF !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_busy: got %b, required 1", FetchBusyF); end
    vectors++; if (imem_req !== 1'b1)   begin miscompares++; $display("[TB] FAIL reset_req: got %b, required 1", imem_req); end
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_addr: got %h, required %h", imem_addr, 32'h0); end
`ifdef MISALIGN_TRAP_EN
    vectors++; if (MisalignF !== 1'b0)  begin miscompares++; $display("[TB] FAIL reset_misalign: got %b, required 0", MisalignF); end
`endif
  endtask

  task automatic test_basic();
    logic [31:0] ePc  [6];
    logic [31:0] eIns [6];
    logic        eReq [6];
    logic        eVal [6];
    ePc  = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h4, 32'h4};
    eIns = '{NOP, NOP, 32'h0050_0093, NOP, NOP, 32'h0010_0113};
    eReq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    eVal = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    reset = 1'b0; gntEn = 1'b1; memLat = 1;
    expQ.push_back('{32'h0, 32'h0050_0093});
    expQ.push_back('{32'h4, 32'h0010_0113});
    for (int i = 0; i < 6; i++) begin
      vectors++; if (PCF !== ePc[i])        begin miscompares++; $display("[TB] FAIL basic_pcf[%0d]: got %h, required %h", i, PCF, ePc[i]); end
      vectors++; if (imem_addr !== ePc[i])  begin miscompares++; $display("[TB] FAIL basic_addr[%0d]: got %h, required %h", i, imem_addr, ePc[i]); end
      vectors++; if (imem_req !== eReq[i])  begin miscompares++; $display("[TB] FAIL basic_req[%0d]: got %b, required %b", i, imem_req, eReq[i]); end
      vectors++; if (InstrValidF !== eVal[i]) begin miscompares++; $display("[TB] FAIL basic_valid[%0d]: got %b, required %b", i, InstrValidF, eVal[i]); end
      vectors++; if (InstrF !== eIns[i])    begin miscompares++; $display("[TB] FAIL basic_instr[%0d]: got %h, required %h", i, InstrF, eIns[i]); end
      tick();
    end
  endtask

  task automatic test_stall();
    int n = 0;
    while (InstrValidF !== 1'b1 && n < 10) begin tick(); n++; end
    vectors++;
    if (n >= 10) begin miscompares++; $display("[TB] FAIL stall_wait_hold: got no valid word in %0d cycles, required one", n); return; end
    StallF = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      vectors++; if (PCF !== 32'h8)           begin miscompares++; $display("[TB] FAIL stall_pcf[%0d]: got %h, required %h", k, PCF, 32'h8); end
      vectors++; if (InstrF !== memWord(32'h8)) begin miscompares++; $display("[TB] FAIL stall_instr[%0d]: got %h, required %h", k, InstrF, memWord(32'h8)); end
      vectors++; if (InstrValidF !== 1'b1)    begin miscompares++; $display("[TB] FAIL stall_valid[%0d]: got %b, required 1", k, InstrValidF); end
      vectors++; if (imem_req !== 1'b0)       begin miscompares++; $display("[TB] FAIL stall_req[%0d]: got %b, required 0", k, imem_req); end
    end
    StallF = 1'b0;
    expQ.push_back('{32'h8, memWord(32'h8)});
    tick();
    vectors++; if (PCF !== 32'hC)      begin miscompares++; $display("[TB] FAIL stall_release_pcf: got %h, required %h", PCF, 32'hC); end
    vectors++; if (imem_req !== 1'b1)  begin miscompares++; $display("[TB] FAIL stall_release_req: got %b, required 1", imem_req); end
  endtask

  task automatic test_redirect_wait();
    logic [31:0] eIns [7];
    logic        eReq [7];
    logic        eVal [7];
    eIns = '{NOP, NOP, NOP, NOP, NOP, NOP, memWord(32'h100)};
    eReq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    eVal = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    memLat = 3;
    tick();
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL redir_wait_req: got %b, required 0", imem_req); end
    PCSrcE = 1'b1; PCTargetE = 32'h100;
    expQ.push_back('{32'h100, memWord(32'h100)});
    tick();
    PCSrcE = 1'b0;
    for (int i = 0; i < 7; i++) begin
      vectors++; if (PCF !== 32'h100)       begin miscompares++; $display("[TB] FAIL redir_pcf[%0d]: got %h, required %h", i, PCF, 32'h100); end
      vectors++; if (imem_req !== eReq[i])  begin miscompares++; $display("[TB] FAIL redir_req[%0d]: got %b, required %b", i, imem_req, eReq[i]); end
      vectors++; if (InstrValidF !== eVal[i]) begin miscompares++; $display("[TB] FAIL redir_valid[%0d]: got %b, required %b", i, InstrValidF, eVal[i]); end
      vectors++; if (InstrF !== eIns[i])    begin miscompares++; $display("[TB] FAIL redir_instr[%0d]: got %h, required %h", i, InstrF, eIns[i]); end
      if (eReq[i]) begin
        vectors++; if (imem_addr !== 32'h100) begin miscompares++; $display("[TB] FAIL redir_addr[%0d]: got %h, required %h", i, imem_addr, 32'h100); end
      end
      tick();
    end
  endtask

  task automatic test_redirect_stall();
    int n = 0;
    memLat = 1;
    while (InstrValidF !== 1'b1 && n < 10) begin tick(); n++; end
    vectors++;
    if (n >= 10) begin miscompares++; $display("[TB] FAIL rstall_wait_hold: got no valid word in %0d cycles, required one", n); return; end
    StallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h200;
    tick();
    vectors++; if (PCF !== 32'h200)      begin miscompares++; $display("[TB] FAIL rstall_pcf: got %h, required %h", PCF, 32'h200); end
    vectors++; if (InstrValidF !== 1'b0) begin miscompares++; $display("[TB] FAIL rstall_valid: got %b, required 0", InstrValidF); end
    vectors++; if (InstrF !== NOP)       begin miscompares++; $display("[TB] FAIL rstall_instr: got %h, required %h", InstrF, NOP); end
    vectors++; if (FetchBusyF !== 1'b1)  begin miscompares++; $display("[TB] FAIL rstall_busy: got %b, required 1", FetchBusyF); end
    vectors++; if (imem_req !== 1'b1)    begin miscompares++; $display("[TB] FAIL rstall_req: got %b, required 1", imem_req); end
    vectors++; if (imem_addr !== 32'h200) begin miscompares++; $display("[TB] FAIL rstall_addr: got %h, required %h", imem_addr, 32'h200); end
    StallF = 1'b0; PCSrcE = 1'b0;
    expQ.push_back('{32'h200, memWord(32'h200)});
    n = 0;
    while (expQ.size() != 0 && n < 20) begin tick(); n++; end
    vectors++; if (n >= 20) begin miscompares++; $display("[TB] FAIL rstall_drain: got %0d pending, required 0", expQ.size()); end
    vectors++; if (PCF !== 32'h204) begin miscompares++; $display("[TB] FAIL rstall_next_pcf: got %h, required %h", PCF, 32'h204); end
  endtask

  task automatic test_reset_mid();
    memLat = 3;
    tick();
    reset = 1'b1; gntEn = 1'b0;
    #1;
    vectors++; if (PCF !== 32'h0)        begin miscompares++; $display("[TB] FAIL rmid_pcf: got %h, required %h", PCF, 32'h0); end
    vectors++; if (InstrValidF !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_valid: got %b, required 0", InstrValidF); end
    vectors++; if (imem_req !== 1'b1)    begin miscompares++; $display("[TB] FAIL rmid_req: got %b, required 1", imem_req); end
    tick();
    reset = 1'b0;
    tick();
    tick();
    vectors++; if (InstrValidF !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_late_valid: got %b, required 0", InstrValidF); end
    vectors++; if (InstrF !== NOP)       begin miscompares++; $display("[TB] FAIL rmid_late_instr: got %h, required %h", InstrF, NOP); end
    vectors++; if (imem_req !== 1'b1)    begin miscompares++; $display("[TB] FAIL rmid_late_req: got %b, required 1", imem_req); end
    vectors++; if (imem_addr !== 32'h0)  begin miscompares++; $display("[TB] FAIL rmid_late_addr: got %h, required %h", imem_addr, 32'h0); end
    gntEn = 1'b1; memLat = 1;
    expQ.push_back('{32'h0, 32'h0050_0093});
    tick();
    tick();
    vectors++; if (InstrValidF !== 1'b1)       begin miscompares++; $display("[TB] FAIL rmid_refetch_valid: got %b, required 1", InstrValidF); end
    vectors++; if (InstrF !== 32'h0050_0093)   begin miscompares++; $display("[TB] FAIL rmid_refetch_instr: got %h, required %h", InstrF, 32'h0050_0093); end
    tick();
    vectors++; if (PCF !== 32'h4) begin miscompares++; $display("[TB] FAIL rmid_next_pcf: got %h, required %h", PCF, 32'h4); end
  endtask

  task automatic test_misalign();
    int n = 0;
    logic [31:0] ePc;
`ifdef MISALIGN_TRAP_EN
    ePc = 32'h4;
`else
    ePc = 32'h100;
`endif
    PCSrcE = 1'b1; PCTargetE = 32'h102;
    tick();
    PCSrcE = 1'b0;
    vectors++; if (PCF !== ePc)          begin miscompares++; $display("[TB] FAIL mis_pcf: got %h, required %h", PCF, ePc); end
    vectors++; if (imem_req !== 1'b0)    begin miscompares++; $display("[TB] FAIL mis_drop_req: got %b, required 0", imem_req); end
    vectors++; if (InstrValidF !== 1'b0) begin miscompares++; $display("[TB] FAIL mis_valid: got %b, required 0", InstrValidF); end
`ifdef MISALIGN_TRAP_EN
    vectors++; if (MisalignF !== 1'b1)   begin miscompares++; $display("[TB] FAIL mis_pulse: got %b, required 1", MisalignF); end
`endif
    tick();
    vectors++; if (imem_req !== 1'b1)    begin miscompares++; $display("[TB] FAIL mis_req: got %b, required 1", imem_req); end
    vectors++; if (imem_addr !== ePc)    begin miscompares++; $display("[TB] FAIL mis_addr: got %h, required %h", imem_addr, ePc); end
`ifdef MISALIGN_TRAP_EN
    vectors++; if (MisalignF !== 1'b0)   begin miscompares++; $display("[TB] FAIL mis_pulse_end: got %b, required 0", MisalignF); end
`endif
    expQ.push_back('{ePc, memWord(ePc)});
    while (expQ.size() != 0 && n < 20) begin tick(); n++; end
    vectors++; if (n >= 20) begin miscompares++; $display("[TB] FAIL mis_drain: got %0d pending, required 0", expQ.size()); end
    vectors++; if (PCF !== ePc + 32'h4) begin miscompares++; $display("[TB] FAIL mis_next_pcf: got %h, required %h", PCF, ePc + 32'h4); end
  endtask

  task automatic test_wrap();
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    tick();
    PCSrcE = 1'b0;
    vectors++; if (PCF !== 32'hFFFF_FFFC) begin miscompares++; $display("[TB] FAIL wrap_pcf: got %h, required %h", PCF, 32'hFFFF_FFFC); end
    vectors++; if (PCPlus4F !== 32'h0)    begin miscompares++; $display("[TB] FAIL wrap_pcplus4: got %h, required %h", PCPlus4F, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_stall();
    test_reset_mid();
    test_misalign();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion by %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
